// File: rtl/hello_pkg.sv
// Shared definitions for the "HELLO" generator and receiver.
// Holds the character set, the one-hot state encoding and the gap limits.
package hello_pkg;

  localparam logic [7:0] CHAR_H = 8'h48;
  localparam logic [7:0] CHAR_E = 8'h45;
  localparam logic [7:0] CHAR_L = 8'h4C;
  localparam logic [7:0] CHAR_O = 8'h4F;

  localparam int         FRAME_LEN = 5;
  localparam logic [2:0] LAST_IDX  = 3'd4;

  localparam int GAP_CYC_MIN = 1;
  localparam int GAP_CYC_MAX = 255;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    SEND = 3'b010,
    GAP  = 3'b100
  } state_t;

  // Keeps an out-of-range gap setting inside the supported 1..255 window.
  function automatic logic [7:0] gap_limit(input int cyc);
    if (cyc < GAP_CYC_MIN) begin
      return 8'(GAP_CYC_MIN);
    end else if (cyc > GAP_CYC_MAX) begin
      return 8'(GAP_CYC_MAX);
    end else begin
      return 8'(cyc);
    end
  endfunction

endpackage

// File: rtl/hello_rom.sv
// Character lookup for the "HELLO" frame.
// Indices past the last character read as 0x00.
module hello_rom
  import hello_pkg::*;
(
  input  logic [2:0] idx,
  output logic [7:0] char_byte
);

  always_comb begin
    char_byte = 8'h00;
    case (idx)
      3'd0:    char_byte = CHAR_H;
      3'd1:    char_byte = CHAR_E;
      3'd2:    char_byte = CHAR_L;
      3'd3:    char_byte = CHAR_L;
      3'd4:    char_byte = CHAR_O;
      default: char_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/hello_gen.sv
// Streams the five-byte "HELLO" frame over a valid/ready handshake.
// Frames can repeat with a fixed idle gap between them.
module hello_gen
  import hello_pkg::*;
#(
  parameter int GAP_CYC = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       start,
  input  logic       repeat_en,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_cnt
);

  localparam logic [7:0] GAP_LAST = gap_limit(GAP_CYC) - 8'd1;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  logic [2:0] idx_nxt;
  logic [7:0] gap_cnt;
  logic [7:0] gap_nxt;
  logic [7:0] cnt_nxt;
  logic       done_nxt;
  logic       accept;
  logic [7:0] rom_byte;

  assign accept = valid & ready;

  // The ROM is addressed with the next index so data can be registered.
  hello_rom u_rom (
    .idx       (idx_nxt),
    .char_byte (rom_byte)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    gap_nxt   = gap_cnt;
    cnt_nxt   = frame_cnt;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SEND;
          idx_nxt   = 3'd0;
        end
      end
      SEND: begin
        if (accept) begin
          if (idx == LAST_IDX) begin
            done_nxt  = 1'b1;
            cnt_nxt   = frame_cnt + 8'd1;
            idx_nxt   = 3'd0;
            gap_nxt   = 8'd0;
            state_nxt = repeat_en ? GAP : IDLE;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = SEND;
          idx_nxt   = 3'd0;
          gap_nxt   = 8'd0;
        end else begin
          gap_nxt = gap_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 3'd0;
        gap_nxt   = 8'd0;
      end
    endcase
  end

  // Outputs are registered from the next-state view, so none of them
  // follow ready/start/repeat_en combinationally.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      gap_cnt   <= 8'd0;
      valid     <= 1'b0;
      data      <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 8'h00;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      gap_cnt   <= gap_nxt;
      valid     <= (state_nxt == SEND);
      data      <= (state_nxt == SEND) ? rom_byte : 8'h00;
      busy      <= (state_nxt != IDLE);
      done      <= done_nxt;
      frame_cnt <= cnt_nxt;
    end
  end

endmodule

// File: doc/hello_gen.md
HELLO_GEN -- requirements
Module: hello_gen

Interface
REQ-001 SHALL have parameter GAP_CYC, default 4: idle cycles inserted between repeated frames, range 1..255.
REQ-002 SHALL have port Clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port Rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a frame; sampled only in IDLE.
REQ-005 SHALL have port repeat  input  1  sampled when a frame's last byte is accepted; 1 = send another frame after the gap.
REQ-006 SHALL have port ready  input  1  downstream accepts data when ready=1 and valid=1 on the same edge.
REQ-007 SHALL have port data  output  8  current character byte.
REQ-008 SHALL have port valid  output  1  data holds a byte for transfer.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse after a frame's last byte is accepted.
REQ-011 SHALL have port frame_cnt  output  8  count of completed frames.

Function
REQ-012 SHALL transmit each frame as exactly five bytes in order: 0x48 "H", 0x45 "E", 0x4C "L", 0x4C "L", 0x4F "O".
REQ-013 SHALL implement the states IDLE, SEND and GAP, with a 3-bit char index 0..4 active in SEND.
REQ-014 SHALL transition IDLE->SEND on the edge where start=1, setting index=0; valid=1 and data=0x48 from the next cycle (1-cycle latency).
REQ-015 SHALL hold data and valid stable while valid=1 and ready=0; valid never deasserts before acceptance.
REQ-016 SHALL advance the index by one on each accepted byte, allowing back-to-back transfers at one byte per cycle when ready stays 1.
REQ-017 SHALL on acceptance of index 4: pulse done for one cycle, increment frame_cnt modulo 256 (0xFF->0x00), and go to GAP if repeat=1, else to IDLE.
REQ-018 SHALL keep valid=0 in GAP for exactly GAP_CYC cycles, then enter SEND with index=0.
REQ-019 SHALL treat repeat deasserted during GAP as having no effect on the frame in progress; the following frame is decided only at the end of that frame.
REQ-020 SHALL ignore start while busy=1; it is not queued.
REQ-021 SHALL accept start on the cycle after done when that done pulse returned the state to IDLE (start in the IDLE cycle).
REQ-022 SHALL register all outputs; none depends combinationally on ready, start or repeat.

Reset
REQ-023 SHALL on Rst=1 immediately force state=IDLE, index=0, gap counter=0, valid=0, data=0x00, busy=0, done=0, frame_cnt=0x00, including mid-frame and mid-gap.
REQ-024 SHALL discard any partially sent frame on reset; after release, no byte is driven until a new start.

Structure
REQ-025 SHALL place the character constants (H, E, L, O), the state encoding (one-hot, 3 bits) and GAP_CYC limits in shared package hello_pkg, which is also used by the "HELLO" receiver.
REQ-026 SHALL use a single combinational sub-module hello_rom that maps index 0..4 to a byte and returns 0x00 for indices 5..7.

Verification
REQ-027 SHALL verify: start pulse with ready=1 constant, repeat=0 -> valid high for 5 consecutive cycles carrying 48 45 4C 4C 4F, done pulse once, frame_cnt=1, busy low afterward.
REQ-028 SHALL verify: ready toggled randomly with 3-cycle stalls on "E" -> data holds 0x45 with valid=1 during the stall, and the sequence is unchanged with no duplicate or dropped bytes.
REQ-029 SHALL verify: repeat=1, GAP_CYC=4, ready=1 -> two frames separated by exactly 4 cycles of valid=0, then repeat=0 during the second frame -> IDLE, frame_cnt=2.
REQ-030 SHALL verify: start pulses during SEND and during GAP -> ignored, frame_cnt unaffected beyond the expected frames.
REQ-031 SHALL verify: Rst asserted while data=0x4C is stalled -> valid=0, frame_cnt=0 without waiting for a clock edge; a new start then produces a full frame beginning with 0x48.
REQ-032 SHALL verify: 256 completed frames -> frame_cnt wraps from 0xFF to 0x00.
